// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 UART transmitter.
// Bytes arrive over a valid/ready handshake into a small circular FIFO and are
// serialised LSB first. Each bit is held for CLKS_PER_BIT clocks. Frames queued
// back to back leave the line with no idle gap between them.
//
// state      | meaning
// IDLE       | line high, waiting for the FIFO to hold a byte
// START_BIT  | line low for one bit time
// DATA_BITS  | shifting out bits 0..7 of the captured byte
// STOP_BIT   | line high for one bit time; done pulse in its last clock
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_tx_done,
    output logic       tx_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_END    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_PRE    = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fifo_count;

    logic push;
    logic pop;
    logic fifo_empty;

    // o_ready depends only on the registered count, so i_valid never reaches it
    assign o_ready    = (fifo_count != FIFO_FULL);
    assign fifo_empty = (fifo_count == '0);
    assign push       = i_valid && o_ready;
    // A pop happens whenever the FSM starts a frame: from IDLE or from the last stop-bit clock
    assign pop        = !fifo_empty &&
                        ((state == IDLE) || ((state == STOP_BIT) && (bit_cnt == BIT_END)));

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Frame sequencer with registered line, busy and done outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            o_tx      <= 1'b1;
            o_tx_done <= 1'b0;
            tx_busy   <= 1'b0;
        end else begin
            o_tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    o_tx    <= 1'b1;
                    tx_busy <= 1'b0;
                    if (pop) begin
                        shift   <= mem[rd_ptr];
                        o_tx    <= 1'b0;
                        tx_busy <= 1'b1;
                        bit_cnt <= '0;
                        state   <= START_BIT;
                    end
                end
                START_BIT: begin
                    if (bit_cnt == BIT_END) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        o_tx    <= shift[0];
                        state   <= DATA_BITS;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA_BITS: begin
                    if (bit_cnt == BIT_END) begin
                        bit_cnt <= '0;
                        if (bit_idx != 3'd7) begin
                            shift   <= {1'b0, shift[7:1]};
                            bit_idx <= bit_idx + 1'b1;
                            o_tx    <= shift[1];
                        end else begin
                            o_tx  <= 1'b1;
                            state <= STOP_BIT;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP_BIT: begin
                    if (bit_cnt == BIT_END) begin
                        bit_cnt <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            o_tx  <= 1'b0;
                            state <= START_BIT;
                        end else begin
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        // Registered pulse lands exactly on the last stop-bit clock
                        if (bit_cnt == BIT_PRE) begin
                            o_tx_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (8, 4 and 868 clocks per bit) share one clock.
// A line receiver per instance decodes frames; a byte queue and FIFO-count model
// supply the expected values.
module tb_uart_tx;

    localparam int DEPTH = 4;

    typedef struct {
        int         u;
        logic [7:0] d;
        logic       stop;
    } rx_t;

    typedef struct {
        int         u;
        logic [7:0] d;
    } exp_t;

    logic       clk;
    logic       rst_n [3];
    logic       vld   [3];
    logic [7:0] din   [3];
    logic       rdy   [3];
    logic       tx    [3];
    logic       done  [3];
    logic       busy  [3];

    int total = 0;
    int bad   = 0;

    int mcnt     [3];
    int busy_cnt [3];
    int ndone    [3];
    int nrise    [3];
    int saw_low  [3];

    rx_t  rxq  [$];
    exp_t expq [$];

    uart_tx #(.CLKS_PER_BIT(8), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst_n(rst_n[0]), .i_data(din[0]), .i_valid(vld[0]),
        .o_ready(rdy[0]), .o_tx(tx[0]), .o_tx_done(done[0]), .tx_busy(busy[0]));

    uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst_n(rst_n[1]), .i_data(din[1]), .i_valid(vld[1]),
        .o_ready(rdy[1]), .o_tx(tx[1]), .o_tx_done(done[1]), .tx_busy(busy[1]));

    uart_tx #(.CLKS_PER_BIT(868), .FIFO_DEPTH(DEPTH)) dut_c (
        .clk(clk), .rst_n(rst_n[2]), .i_data(din[2]), .i_valid(vld[2]),
        .o_ready(rdy[2]), .o_tx(tx[2]), .o_tx_done(done[2]), .tx_busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // Serial receiver: finds the start bit, samples mid-bit, records byte and stop bit
    task automatic rx_mon(input int u, input int cpb);
        logic [7:0] b;
        logic       s;
        forever begin
            @(negedge clk);
            if (rst_n[u] === 1'b1 && tx[u] === 1'b0) begin
                repeat (cpb / 2) @(negedge clk);
                if (tx[u] === 1'b0) begin
                    for (int k = 0; k < 8; k++) begin
                        repeat (cpb) @(negedge clk);
                        b[k] = tx[u];
                    end
                    repeat (cpb) @(negedge clk);
                    s = tx[u];
                    rxq.push_back('{u, b, s});
                end
            end
        end
    endtask

    initial rx_mon(0, 8);
    initial rx_mon(1, 4);
    initial rx_mon(2, 868);

    // One clock: accepted bytes enter the expected queue; FIFO count is tracked
    // from frame starts (busy rising, or busy held across a done pulse).
    task automatic tick();
        logic       bp  [3];
        logic       dp  [3];
        logic       acc [3];
        logic [7:0] dd  [3];
        for (int u = 0; u < 3; u++) begin
            bp[u]  = busy[u];
            dp[u]  = done[u];
            acc[u] = vld[u] && rdy[u] && rst_n[u];
            dd[u]  = din[u];
        end
        @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            if (!rst_n[u]) begin
                mcnt[u] = 0;
            end else begin
                if (acc[u]) begin
                    mcnt[u]++;
                    expq.push_back('{u, dd[u]});
                end
                if (busy[u] && (!bp[u] || dp[u])) mcnt[u]--;
                if (busy[u]) busy_cnt[u]++;
                if (busy[u] && !bp[u]) nrise[u]++;
                if (done[u]) ndone[u]++;
                if (!rdy[u]) saw_low[u] = 1;
                chk($sformatf("ready_u%0d", u), rdy[u], (mcnt[u] != DEPTH));
            end
        end
    endtask

    task automatic push(input int u, input logic [7:0] d);
        int   n   = 0;
        logic acc = 1'b0;
        vld[u] = 1'b1;
        din[u] = d;
        while (!acc && n < 2000) begin
            acc = rdy[u];
            tick();
            n++;
        end
        vld[u] = 1'b0;
        chk($sformatf("push_accept_u%0d", u), acc, 1);
    endtask

    task automatic drain(input int u, input int lim, input string tag);
        int n = 0;
        while ((busy[u] || mcnt[u] != 0) && n < lim) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, (busy[u] || mcnt[u] != 0), 0);
        repeat (4) tick();
    endtask

    task automatic purge(input int u);
        rx_t  kr [$];
        exp_t ke [$];
        foreach (rxq[i])  if (rxq[i].u != u)  kr.push_back(rxq[i]);
        foreach (expq[i]) if (expq[i].u != u) ke.push_back(expq[i]);
        rxq  = kr;
        expq = ke;
    endtask

    task automatic check_unit(input int u, input string tag);
        rx_t  g [$];
        exp_t e [$];
        foreach (rxq[i])  if (rxq[i].u == u)  g.push_back(rxq[i]);
        foreach (expq[i]) if (expq[i].u == u) e.push_back(expq[i]);
        chk({tag, "_count"}, g.size(), e.size());
        for (int i = 0; i < g.size() && i < e.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), g[i].d, e[i].d);
            chk($sformatf("%s_stop%0d", tag, i), g[i].stop, 1);
        end
        purge(u);
    endtask

    initial begin
        logic [9:0] frame;
        logic [7:0] b0;
        int         n;
        int         viol;

        for (int u = 0; u < 3; u++) begin
            rst_n[u]    = 1'b0;
            vld[u]      = 1'b0;
            din[u]      = 8'h00;
            mcnt[u]     = 0;
            busy_cnt[u] = 0;
            ndone[u]    = 0;
            nrise[u]    = 0;
            saw_low[u]  = 0;
        end
        tick();
        tick();
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("reset_tx_u%0d", u),   tx[u],   1);
            chk($sformatf("reset_busy_u%0d", u), busy[u], 0);
            chk($sformatf("reset_done_u%0d", u), done[u], 0);
            chk($sformatf("reset_rdy_u%0d", u),  rdy[u],  1);
        end
        for (int u = 0; u < 3; u++) rst_n[u] = 1'b1;
        tick();

        // Loopback unit at 868 clocks per bit runs in the background
        for (int k = 0; k < 4; k++) push(2, 8'($urandom_range(0, 255)));

        // Single 0xA5 frame with exact per-clock line, busy and done
        frame = {1'b1, 8'hA5, 1'b0};
        push(0, 8'hA5);
        chk("single_pre_tx", tx[0], 1);
        chk("single_pre_busy", busy[0], 0);
        tick();
        for (int i = 0; i < 90; i++) begin
            chk($sformatf("single_c%0d", i), {tx[0], busy[0], done[0]},
                {(i < 80) ? frame[i / 8] : 1'b1, (i < 80), (i == 79)});
            tick();
        end
        check_unit(0, "single");

        // Burst of six bytes pushed continuously
        busy_cnt[0] = 0; ndone[0] = 0; nrise[0] = 0; saw_low[0] = 0;
        push(0, 8'h00); push(0, 8'hFF); push(0, 8'h55);
        push(0, 8'hAA); push(0, 8'h01); push(0, 8'h80);
        drain(0, 1000, "burst");
        chk("burst_busy_clocks", busy_cnt[0], 480);
        chk("burst_done_pulses", ndone[0], 6);
        chk("burst_busy_rises", nrise[0], 1);
        chk("burst_ready_dropped", saw_low[0], 1);
        check_unit(0, "burst");

        // Push on the same edge as the stop-to-start pop, with one byte queued
        push(0, 8'h3C);
        tick();
        push(0, 8'hC3);
        n = 0;
        while (done[0] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("simul_done_seen", done[0], 1);
        push(0, 8'h5A);
        push(0, 8'h11);
        push(0, 8'h22);
        chk("simul_rdy_at3", rdy[0], 1);
        push(0, 8'h33);
        chk("simul_rdy_at4", rdy[0], 0);
        drain(0, 1000, "simul");
        check_unit(0, "simul");

        // Reset asserted during data bit 3 of the first of three queued frames
        b0 = 8'($urandom_range(0, 255));
        frame = {1'b1, b0, 1'b0};
        push(0, b0);
        push(0, 8'($urandom_range(0, 255)));
        push(0, 8'($urandom_range(0, 255)));
        repeat (33) tick();
        chk("rst_pre_line", tx[0], frame[4]);
        #1;
        rst_n[0] = 1'b0;
        #1;
        chk("rst_async_tx", tx[0], 1);
        chk("rst_async_busy", busy[0], 0);
        chk("rst_async_rdy", rdy[0], 1);
        chk("rst_async_done", done[0], 0);
        tick();
        rst_n[0] = 1'b1;
        viol = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0) viol++;
        end
        chk("rst_quiet_line", viol, 0);
        purge(0);
        push(0, 8'($urandom_range(0, 255)));
        drain(0, 300, "after_rst");
        check_unit(0, "after_rst");

        // Pointer wrap: 3*DEPTH+1 random bytes with random gaps
        for (int k = 0; k < 3 * DEPTH + 1; k++) begin
            repeat ($urandom_range(0, 12)) tick();
            push(1, 8'($urandom_range(0, 255)));
        end
        drain(1, 2000, "wrap");
        check_unit(1, "wrap");

        drain(2, 45000, "loop");
        check_unit(2, "loop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
